// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: registered multi-port arbiter for one shared downstream resource.
// Registers a one-hot grant, a valid flag and a binary index. These drive the
// interconnect mux selects directly, so none of them has a combinational path
// from the inputs.
// Grant hold policy (BLOCK): "NONE", "REQUEST" or "ACKNOWLEDGE".
// Tie-break (LSB_PRIORITY): "HIGH" means index 0 wins; "LOW" means the highest
// index wins.
// Optional feature macro: AXI_ARB_ROUND_ROBIN_EN.
//   When defined, a round-robin pointer and mask rotate priority past the last
//   grantee.
//   When undefined, arbitration is fixed priority only.
module axi_rr_arbiter #(
  parameter int unsigned PORTS        = 4,
  parameter string       BLOCK        = "REQUEST",
  parameter string       LSB_PRIORITY = "HIGH",
  localparam int unsigned ENC_W       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PORTS-1:0]   request,
  input  logic [PORTS-1:0]   acknowledge,
  output logic [PORTS-1:0]   grant,
  output logic               grant_valid,
  output logic [ENC_W-1:0]   grant_encoded
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_GRANTED = 1'b1;

  localparam bit BLK_NONE = (BLOCK == "NONE");
  localparam bit BLK_ACK  = (BLOCK == "ACKNOWLEDGE");
  localparam bit LSB_HIGH = (LSB_PRIORITY != "LOW");

  logic [0:0]       state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [ENC_W-1:0] enc_q, enc_d;

  logic             release_c;
  logic             arbitrate_c;
  logic [ENC_W:0]   sel_c;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic [ENC_W-1:0] last_q, last_d;
  logic             last_valid_q, last_valid_d;
  logic [PORTS-1:0] rr_mask_c;
  logic [ENC_W:0]   pick_masked_c;
  logic [ENC_W:0]   pick_all_c;
`endif

  // Highest-priority set bit of vec: {found, index}.
  function automatic logic [ENC_W:0] pick(input logic [PORTS-1:0] vec);
    logic [ENC_W:0] res;
    res = '0;
    if (LSB_HIGH) begin
      for (int i = int'(PORTS) - 1; i >= 0; i--) begin
        if (vec[i]) res = {1'b1, ENC_W'(i)};
      end
    end else begin
      for (int i = 0; i < int'(PORTS); i++) begin
        if (vec[i]) res = {1'b1, ENC_W'(i)};
      end
    end
    return res;
  endfunction

  // Release of the current holder under the configured hold policy.
  always_comb begin
    release_c = 1'b0;
    if (BLK_NONE) begin
      release_c = 1'b1;
    end else if (BLK_ACK) begin
      release_c = acknowledge[enc_q];
    end else begin
      release_c = ~request[enc_q];
    end
    arbitrate_c = (state_q == S_IDLE) || release_c;
  end

`ifdef AXI_ARB_ROUND_ROBIN_EN
  // Round-robin selection: ports below the last grantee in priority go first.
  always_comb begin
    rr_mask_c = '0;
    if (last_valid_q) begin
      for (int i = 0; i < int'(PORTS); i++) begin
        if (LSB_HIGH) rr_mask_c[i] = (i > int'(last_q));
        else          rr_mask_c[i] = (i < int'(last_q));
      end
    end
    pick_masked_c = pick(request & rr_mask_c);
    pick_all_c    = pick(request);
    sel_c         = pick_masked_c[ENC_W] ? pick_masked_c : pick_all_c;
  end
`else
  // Fixed-priority selection.
  always_comb begin
    sel_c = pick(request);
  end
`endif

  // Next-state and next-grant logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    enc_d   = enc_q;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    last_d       = last_q;
    last_valid_d = last_valid_q;
`endif
    if (arbitrate_c) begin
      if (sel_c[ENC_W]) begin
        state_d = S_GRANTED;
        enc_d   = sel_c[ENC_W-1:0];
        grant_d = PORTS'(1) << sel_c[ENC_W-1:0];
`ifdef AXI_ARB_ROUND_ROBIN_EN
        last_d       = sel_c[ENC_W-1:0];
        last_valid_d = 1'b1;
`endif
      end else begin
        state_d = S_IDLE;
        enc_d   = '0;
        grant_d = '0;
      end
    end
  end

  // State and output registers; reset clears all outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      enc_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      enc_q   <= enc_d;
    end
  end

`ifdef AXI_ARB_ROUND_ROBIN_EN
  // Last-grant pointer, which starts with no previous grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
    end
  end
`endif

  assign grant         = grant_q;
  assign grant_valid   = (state_q == S_GRANTED);
  assign grant_encoded = enc_q;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Bench for axi_rr_arbiter: five configurations checked against a rank-scan model.
// Instance map:
//   0: REQUEST/HIGH
//   1: ACKNOWLEDGE/HIGH
//   2: NONE/HIGH
//   3: NONE/LOW
//   4: PORTS=1 REQUEST
module tb_axi_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req [5];
  logic [3:0] ack [5];

  logic [3:0] g0, g1, g2, g3;
  logic       g4;
  logic       v0, v1, v2, v3, v4;
  logic [1:0] e0, e1, e2, e3;
  logic       e4;

  int checks = 0;
  int errors = 0;

  int cfg_ports [5] = '{4, 4, 4, 4, 1};
  int cfg_block [5] = '{1, 2, 0, 0, 1};  // 0 NONE, 1 REQUEST, 2 ACKNOWLEDGE
  int cfg_high  [5] = '{1, 1, 1, 0, 1};
  int m_hold [5];
  int m_last [5];

`ifdef AXI_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  axi_rr_arbiter #(.PORTS(4), .BLOCK("REQUEST"), .LSB_PRIORITY("HIGH")) u_req (
    .clk(clk), .rst(rst), .request(req[0]), .acknowledge(ack[0]),
    .grant(g0), .grant_valid(v0), .grant_encoded(e0));
  axi_rr_arbiter #(.PORTS(4), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("HIGH")) u_ack (
    .clk(clk), .rst(rst), .request(req[1]), .acknowledge(ack[1]),
    .grant(g1), .grant_valid(v1), .grant_encoded(e1));
  axi_rr_arbiter #(.PORTS(4), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) u_none (
    .clk(clk), .rst(rst), .request(req[2]), .acknowledge(ack[2]),
    .grant(g2), .grant_valid(v2), .grant_encoded(e2));
  axi_rr_arbiter #(.PORTS(4), .BLOCK("NONE"), .LSB_PRIORITY("LOW")) u_low (
    .clk(clk), .rst(rst), .request(req[3]), .acknowledge(ack[3]),
    .grant(g3), .grant_valid(v3), .grant_encoded(e3));
  axi_rr_arbiter #(.PORTS(1), .BLOCK("REQUEST"), .LSB_PRIORITY("HIGH")) u_one (
    .clk(clk), .rst(rst), .request(req[4][0]), .acknowledge(ack[4][0]),
    .grant(g4), .grant_valid(v4), .grant_encoded(e4));

  // Packed observation {grant[3:0], valid, enc[1:0]} of one instance.
  function automatic logic [6:0] obs(int i);
    case (i)
      0:       return {g0, v0, e0};
      1:       return {g1, v1, e1};
      2:       return {g2, v2, e2};
      3:       return {g3, v3, e3};
      4:       return {3'b000, g4, v4, 1'b0, e4};
      default: return 7'd0;
    endcase
  endfunction

  // Model: scan ports in priority-rank order, starting after the last grantee when rotating.
  function automatic int m_pick(int i, logic [3:0] r);
    int p;
    int start;
    int rk;
    int idx;
    p = cfg_ports[i];
    start = 0;
    if (RR && m_last[i] >= 0)
      start = ((cfg_high[i] != 0) ? m_last[i] : (p - 1 - m_last[i])) + 1;
    for (int k = 0; k < p; k++) begin
      rk  = (start + k) % p;
      idx = (cfg_high[i] != 0) ? rk : (p - 1 - rk);
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [6:0] m_exp(int i);
    if (m_hold[i] < 0) return 7'd0;
    return {4'(1 << m_hold[i]), 1'b1, 2'(m_hold[i])};
  endfunction

  // One clock edge; the model samples the same inputs, and outputs are read 1 ns later.
  task automatic step();
    int nh [5];
    int nl [5];
    bit rel;
    for (int i = 0; i < 5; i++) begin
      nh[i] = m_hold[i];
      nl[i] = m_last[i];
      if (!rst) begin
        if (m_hold[i] < 0)          rel = 1'b1;
        else if (cfg_block[i] == 0) rel = 1'b1;
        else if (cfg_block[i] == 1) rel = !req[i][m_hold[i]];
        else                        rel = ack[i][m_hold[i]];
        if (rel) begin
          nh[i] = m_pick(i, req[i]);
          if (nh[i] >= 0) nl[i] = nh[i];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      m_hold[i] = rst ? -1 : nh[i];
      m_last[i] = rst ? -1 : nl[i];
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 5; i++) begin
      req[i] = 4'h0;
      ack[i] = 4'hF;
    end
    step();
    for (int i = 0; i < 5; i++) ack[i] = 4'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] o;
    for (int i = 0; i < 5; i++) begin
      req[i] = 4'hF;
      ack[i] = 4'h0;
    end
    rst = 1'b1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      o = obs(i);
      checks++;
      if (o !== 7'd0) begin
        errors++;
        $display("FAIL reset_hold inst%0d got %b want 0000_0_00", i, o);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (obs(0) !== {4'b0001, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL first_grant got %b want 0001_1_00", obs(0));
    end
    checks++;
    if (obs(4) !== {4'b0001, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL first_grant_p1 got %b want 0001_1_00", obs(4));
    end
    step();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      o = obs(i);
      checks++;
      if (o !== 7'd0) begin
        errors++;
        $display("FAIL async_reset inst%0d got %b want 0000_0_00", i, o);
      end
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_request_hold();
    idle_all();
    req[0] = 4'b0110;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({g0, v0, e0} !== {4'b0010, 1'b1, 2'd1}) begin
        errors++;
        $display("FAIL req_hold cycle%0d got %b_%b_%0d want 0010_1_1", k, g0, v0, e0);
      end
      if (k < 3) step();
    end
    req[0] = 4'b0100;
    step();
    checks++;
    if ({g0, v0, e0} !== {4'b0100, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL req_handover got %b_%b_%0d want 0100_1_2", g0, v0, e0);
    end
  endtask

  task automatic test_ack_hold();
    idle_all();
    req[1] = 4'b0100;
    step();
    checks++;
    if ({g1, v1, e1} !== {4'b0100, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL ack_grant got %b_%b_%0d want 0100_1_2", g1, v1, e1);
    end
    req[1] = 4'b0000;
    step();
    checks++;
    if ({g1, v1, e1} !== {4'b0100, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL ack_drop_req got %b_%b_%0d want 0100_1_2", g1, v1, e1);
    end
    req[1] = 4'b1000;
    ack[1] = 4'b1000;
    step();
    checks++;
    if ({g1, v1, e1} !== {4'b0100, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL ack_other got %b_%b_%0d want 0100_1_2", g1, v1, e1);
    end
    req[1] = 4'b0000;
    ack[1] = 4'b0100;
    step();
    ack[1] = 4'b0000;
    checks++;
    if ({g1, v1, e1} !== {4'b0000, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL ack_release got %b_%b_%0d want 0000_0_0", g1, v1, e1);
    end
  endtask

  task automatic test_rotation();
    int want;
    do_reset();
    req[2] = 4'hF;
    for (int k = 0; k < 8; k++) begin
      step();
      want = RR ? (k % 4) : 0;
      checks++;
      if ({g2, v2, e2} !== {4'(1 << want), 1'b1, 2'(want)}) begin
        errors++;
        $display("FAIL rotation cycle%0d got %b_%b_%0d want enc %0d", k, g2, v2, e2, want);
      end
    end
  endtask

  task automatic test_low_priority();
    int want;
    do_reset();
    req[3] = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      step();
      want = (RR && k == 1) ? 0 : 2;
      checks++;
      if ({g3, v3, e3} !== {4'(1 << want), 1'b1, 2'(want)}) begin
        errors++;
        $display("FAIL low_prio cycle%0d got %b_%b_%0d want enc %0d", k, g3, v3, e3, want);
      end
    end
  endtask

  task automatic test_single_port();
    idle_all();
    req[4] = 4'b0001;
    step();
    checks++;
    if ({g4, v4, e4} !== 3'b110) begin
      errors++;
      $display("FAIL p1_grant got %b_%b_%b want 1_1_0", g4, v4, e4);
    end
    req[4] = 4'b0000;
    step();
    checks++;
    if ({g4, v4, e4} !== 3'b000) begin
      errors++;
      $display("FAIL p1_release got %b_%b_%b want 0_0_0", g4, v4, e4);
    end
  endtask

  task automatic test_random();
    logic [6:0] o;
    logic [6:0] w;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 5; i++) begin
        req[i] = 4'($urandom) | (((n % 8) < 4) ? 4'(m_hold[i] >= 0 ? (1 << m_hold[i]) : 0) : 4'h0);
        ack[i] = 4'($urandom) & 4'($urandom);
      end
      step();
      for (int i = 0; i < 5; i++) begin
        o = obs(i);
        w = m_exp(i);
        checks++;
        if (o !== w) begin
          errors++;
          $display("FAIL random n%0d inst%0d got %b want %b", n, i, o, w);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req[i] = 4'h0;
      ack[i] = 4'h0;
      m_hold[i] = -1;
      m_last[i] = -1;
    end
    test_reset();
    test_request_hold();
    test_ack_hold();
    test_rotation();
    test_low_priority();
    test_single_port();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rr_arbiter.md
# axi_rr_arbiter

Registered multi-port arbiter sharing one downstream resource (AXI master port, crossbar output, DMA channel) among `PORTS` requesters. Each cycle it selects a requester by fixed priority or round-robin, registers a one-hot grant plus binary index, and holds the grant per the `BLOCK` policy. It sits in front of the AXI interconnect muxes and drives their select inputs directly.

## Interface
Parameters:
- `PORTS`, 4, number of requesters (1..32)
- `BLOCK`, "REQUEST", grant hold policy: "NONE", "REQUEST", "ACKNOWLEDGE"
- `LSB_PRIORITY`, "HIGH", "HIGH" = index 0 wins ties; "LOW" = highest index wins

Ports:
- `clk` in 1 — single clock, all logic rising-edge
- `rst` in 1 — asynchronous, active-high reset
- `request` in PORTS — per-port request level
- `acknowledge` in PORTS — per-port release strobe (used only when BLOCK="ACKNOWLEDGE")
- `grant` out PORTS — one-hot registered grant
- `grant_valid` out 1 — a grant is held
- `grant_encoded` out $clog2(PORTS) (min 1) — binary index of granted port

## Operation
- Two states: IDLE (`grant_valid`=0) and GRANTED (`grant_valid`=1).
- Release condition for holder `g`: "NONE" every cycle; "REQUEST" when `request[g]`=0 at the clock edge; "ACKNOWLEDGE" when `acknowledge[g]`=1 at the clock edge. In "ACKNOWLEDGE" mode a dropped request alone does not release.
- Arbitration happens at any edge in IDLE, or at an edge where the release condition holds. Candidates = current `request` bits, including the releasing holder's bit if still set.
- Fixed priority: pick highest-priority set bit per `LSB_PRIORITY`.
- Round-robin: mask = ports strictly lower priority than last granted index. If `request & mask` ≠ 0, pick highest-priority bit in it; else pick from unmasked `request`. Last-grant pointer updates only when a new grant is issued.
- No candidates: go/stay IDLE; `grant`=0; `grant_encoded` = 0.
- Moving from one holder to the next takes no idle cycle.
- `acknowledge` on a non-granted port is ignored. `request` on a non-granted port never pre-empts a holder.
- PORTS=1: grant follows policy with index always 0.

## Timing
- Reset: `grant`=0, `grant_valid`=0, `grant_encoded`=0, round-robin pointer = "no previous grant" (first arbitration is pure priority). Asserting `rst` mid-grant clears all outputs immediately, without waiting for a clock edge.
- Latency: request sampled at edge N → `grant` visible after edge N (one cycle). Release sampled at edge N → next grant or IDLE after the same edge N.
- `grant`, `grant_valid` and `grant_encoded` always change together. `grant` = 1 << `grant_encoded` when valid. All are pure flops, with no combinational path from inputs.

## Configuration
- `AXI_ARB_ROUND_ROBIN_EN` defined: round-robin mask and last-grant pointer are built as described.
- Not defined: fixed priority only; pointer and mask logic are removed. All other behaviour is identical.

## Test plan
PORTS=4, LSB_PRIORITY="HIGH" unless stated.
- Reset: hold `rst`=1 with `request`=4'b1111, then pulse `rst` mid-grant → all outputs 0 asynchronously. First grant after deassert is port 0.
- BLOCK="REQUEST", request=4'b0110 held → grant=4'b0010 one cycle later, held while bit1 stays high. Drop bit1 → next cycle grant=4'b0100, no idle cycle.
- BLOCK="ACKNOWLEDGE", grant port 2; drop request[2] without ack → grant held. Pulse acknowledge[3] → no change. Pulse acknowledge[2] with request=0 → IDLE next cycle.
- Round-robin (macro on), BLOCK="NONE", request=4'b1111 constant → grant_encoded sequence 0,1,2,3,0,… Macro off → constant 0.
- LSB_PRIORITY="LOW", fixed priority, request=4'b0101 → grant_encoded=2. With PORTS=1 and request=1 → grant=1, grant_encoded=0.
